// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson code receiver.
// FSM states, default geometry and the index-width helper.
package johnson_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int N_DEF        = 8;
  localparam int LOCK_CNT_DEF = 2;

  function automatic int idx_w(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_rx_if.sv
// Sample/decode bundle for johnson_rx.
// master drives samples, slave is the receiver side.
interface johnson_rx_if
  import johnson_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ERR_W = 8
);

  logic [0:N-1]          in_code;
  logic                  in_valid;
  logic [idx_w(N)-1:0]   idx;
  logic                  idx_valid;
  logic                  locked;
  logic                  code_err;
  logic                  seq_err;
  logic [ERR_W-1:0]      err_cnt;

  modport master (
    output in_code,
    output in_valid,
    input  idx,
    input  idx_valid,
    input  locked,
    input  code_err,
    input  seq_err,
    input  err_cnt
  );

  modport slave (
    input  in_code,
    input  in_valid,
    output idx,
    output idx_valid,
    output locked,
    output code_err,
    output seq_err,
    output err_cnt
  );

endinterface

// File: rtl/johnson_code_map.sv
// Combinational Johnson code to state-index map.
// A code is legal when it has at most one 0/1 transition.
module johnson_code_map
  import johnson_pkg::*;
#(
  parameter int N = N_DEF
)(
  input  logic [0:N-1]        code_i,
  output logic [idx_w(N)-1:0] idx_o,
  output logic                legal_o
);

  localparam int IW = idx_w(N);

  int trans;
  int ones;
  int k;

  always_comb begin
    trans = 0;
    ones  = 0;
    k     = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (code_i[i] != code_i[i+1]) trans++;
    end
    for (int i = 0; i < N; i++) begin
      if (code_i[i]) ones++;
    end
    // Leading ones give k=1..N; leading zeros
    // followed by ones give k=N+zeros.
    if (code_i[0])
      k = ones;
    else if (ones == 0)
      k = 0;
    else
      k = N + (N - ones);
  end

  assign idx_o   = IW'(k);
  assign legal_o = (trans <= 1);

endmodule

// File: rtl/johnson_rx.sv
// Johnson code receiver: decode, sequence lock, error count.
// Optional onehot output under JOHNSON_RX_ONEHOT_EN.
module johnson_rx
  import johnson_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W    = 8
)(
  input  logic                clk,
  input  logic                r,
  input  logic [0:N-1]        in_code,
  input  logic                in_valid,
  output logic [idx_w(N)-1:0] idx,
  output logic                idx_valid,
  output logic                locked,
  output logic                code_err,
  output logic                seq_err,
`ifdef JOHNSON_RX_ONEHOT_EN
  output logic [2*N-1:0]      onehot,
`endif
  output logic [ERR_W-1:0]    err_cnt
);

  localparam int IW = idx_w(N);
  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam logic [SW-1:0] LOCK_V = SW'(LOCK_CNT);
  localparam logic [IW-1:0] LAST = IW'(2 * N - 1);

  logic [IW-1:0]    map_idx;
  logic             map_legal;

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    prev_q;
  logic [SW-1:0]    step_q;
  logic             idx_valid_q;
  logic             locked_q;
  logic             code_err_q;
  logic             seq_err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [IW-1:0]    exp_d;
  logic [SW-1:0]    step_d;
  logic [ERR_W-1:0] err_cnt_d;

  johnson_code_map #(.N(N)) u_map (
    .code_i  (in_code),
    .idx_o   (map_idx),
    .legal_o (map_legal)
  );

  assign exp_d  = (prev_q == LAST) ? '0
                : prev_q + IW'(1);
  assign step_d = step_q + SW'(1);
  assign err_cnt_d = (&err_cnt_q) ? err_cnt_q
                   : err_cnt_q + ERR_W'(1);

`ifdef JOHNSON_RX_ONEHOT_EN
  localparam logic [2*N-1:0] ONE = 1;
  logic [2*N-1:0] onehot_q;

  always_ff @(posedge clk) begin
    if (r)
      onehot_q <= '0;
    else if (in_valid && map_legal)
      onehot_q <= ONE << map_idx;
    else
      onehot_q <= '0;
  end

  assign onehot = onehot_q;
`endif

  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= SEARCH;
      idx_q       <= '0;
      prev_q      <= '0;
      step_q      <= '0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      idx_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      if (in_valid) begin
        if (!map_legal) begin
          code_err_q <= 1'b1;
          step_q     <= '0;
          state_q    <= SEARCH;
          locked_q   <= 1'b0;
          err_cnt_q  <= err_cnt_d;
        end else begin
          idx_q       <= map_idx;
          idx_valid_q <= 1'b1;
          prev_q      <= map_idx;
          unique case (state_q)
            SEARCH: begin
              if (map_idx == exp_d) begin
                step_q <= step_d;
                if (step_d >= LOCK_V) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                step_q <= '0;
              end
            end
            LOCKED: begin
              if (map_idx != exp_d) begin
                seq_err_q <= 1'b1;
                step_q    <= '0;
                state_q   <= SEARCH;
                locked_q  <= 1'b0;
                err_cnt_q <= err_cnt_d;
              end
            end
            default: begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = locked_q;
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_johnson_rx.sv
// Directed bench for johnson_rx (N=8, LOCK_CNT=2, ERR_W=8).
// Snapshot order: idx, idx_valid, locked, code_err, seq_err, err_cnt.
module tb_johnson_rx;
  import johnson_pkg::*;

  logic clk = 1'b0;
  logic r   = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  johnson_rx_if #(.N(8), .ERR_W(8)) bus ();

`ifdef JOHNSON_RX_ONEHOT_EN
  logic [15:0] onehot;
`endif

  johnson_rx dut (
    .clk       (clk),
    .r         (r),
    .in_code   (bus.in_code),
    .in_valid  (bus.in_valid),
    .idx       (bus.idx),
    .idx_valid (bus.idx_valid),
    .locked    (bus.locked),
    .code_err  (bus.code_err),
    .seq_err   (bus.seq_err),
`ifdef JOHNSON_RX_ONEHOT_EN
    .onehot    (onehot),
`endif
    .err_cnt   (bus.err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] snap();
    return {bus.idx, bus.idx_valid, bus.locked,
            bus.code_err, bus.seq_err, bus.err_cnt};
  endfunction

  task automatic smp(input logic [0:7] c,
                     input logic v);
    bus.in_code  = c;
    bus.in_valid = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    r = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    r = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    do_reset();
    e = '0;
    total_cnt++;
    if (snap() !== e)
      $display("FAIL reset got=%h exp=%h", snap(), e);
    else pass_cnt++;
  endtask

  task automatic test_lock();
    logic [15:0] e;
    do_reset();
    smp(8'b00000000, 1'b1);
    e = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL lock_k0 got=%h exp=%h", snap(), e);
    else pass_cnt++;
    smp(8'b10000000, 1'b1);
    e = {4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL lock_k1 got=%h exp=%h", snap(), e);
    else pass_cnt++;
    smp(8'b11000000, 1'b1);
    e = {4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL lock_k2 got=%h exp=%h", snap(), e);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    do_reset();
    smp(8'b00000111, 1'b1);
    smp(8'b00000011, 1'b1);
    smp(8'b00000001, 1'b1);
    e = {4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL wrap_k15 got=%h exp=%h", snap(), e);
    else pass_cnt++;
    smp(8'b00000000, 1'b1);
    e = {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL wrap_k0 got=%h exp=%h", snap(), e);
    else pass_cnt++;
  endtask

  task automatic test_seq_err();
    logic [15:0] e;
    do_reset();
    smp(8'b10000000, 1'b1);
    smp(8'b11000000, 1'b1);
    smp(8'b11100000, 1'b1);
    e = {4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL seq_k3 got=%h exp=%h", snap(), e);
    else pass_cnt++;
    smp(8'b11111000, 1'b1);
    e = {4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL seq_skip got=%h exp=%h", snap(), e);
    else pass_cnt++;
    smp(8'b11111000, 1'b0);
    e = {4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL seq_after got=%h exp=%h", snap(), e);
    else pass_cnt++;
  endtask

  task automatic test_code_err();
    logic [15:0] e;
    do_reset();
    smp(8'b00000000, 1'b1);
    smp(8'b10000000, 1'b1);
    smp(8'b11000000, 1'b1);
    smp(8'b10100000, 1'b1);
    e = {4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL code_err got=%h exp=%h", snap(), e);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic [15:0] e;
    do_reset();
    for (int i = 0; i < 259; i++)
      smp(8'b10100000, 1'b1);
    e = {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hff};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL sat_cnt got=%h exp=%h", snap(), e);
    else pass_cnt++;
    smp(8'b11100000, 1'b1);
    e = {4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hff};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL sat_legal got=%h exp=%h", snap(), e);
    else pass_cnt++;
    r = 1'b1;
    smp(8'b11110000, 1'b1);
    r = 1'b0;
    bus.in_valid = 1'b0;
    e = '0;
    total_cnt++;
    if (snap() !== e)
      $display("FAIL sat_reset got=%h exp=%h", snap(), e);
    else pass_cnt++;
`ifdef JOHNSON_RX_ONEHOT_EN
    total_cnt++;
    if (onehot !== 16'h0000)
      $display("FAIL sat_onehot got=%h exp=0000", onehot);
    else pass_cnt++;
`endif
  endtask

  task automatic test_hold();
    logic [15:0] e;
    int bad;
    do_reset();
    smp(8'b11100000, 1'b1);
    smp(8'b11110000, 1'b1);
    smp(8'b11111000, 1'b1);
    e = {4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL hold_k5 got=%h exp=%h", snap(), e);
    else pass_cnt++;
`ifdef JOHNSON_RX_ONEHOT_EN
    total_cnt++;
    if (onehot !== 16'h0020)
      $display("FAIL onehot_k5 got=%h exp=0020", onehot);
    else pass_cnt++;
`endif
    e = {4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      smp(8'($urandom), 1'b0);
      if (snap() !== e) begin
        bad++;
        $display("FAIL hold_idle%0d got=%h exp=%h",
                 i, snap(), e);
      end
    end
    total_cnt++;
    if (bad == 0) pass_cnt++;
    smp(8'b11111100, 1'b1);
    e = {4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    total_cnt++;
    if (snap() !== e)
      $display("FAIL hold_k6 got=%h exp=%h", snap(), e);
    else pass_cnt++;
  endtask

  initial begin
    bus.in_code  = '0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_lock();
    test_wrap();
    test_seq_err();
    test_code_err();
    test_saturate();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
